// File: rtl/hd_leakage_accumulator_pkg.sv
// Shared types and default widths for the Hamming-distance leakage accumulator.
// ACC_MAX is the saturation ceiling for the default accumulator width.
package hd_leakage_accumulator_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DATA_W    = 4;
   localparam int SUM_W     = DATA_W + 1;
   localparam int HD_W      = 4;
   localparam int ACC_W_DEF = 16;

   localparam logic [ACC_W_DEF-1:0] ACC_MAX = {ACC_W_DEF{1'b1}};

endpackage

// File: rtl/hd_popcount.sv
// Combinational population count of a W-bit vector.
module hd_popcount #(
   parameter int W     = 4,
   parameter int CNT_W = $clog2(W + 1)
) (
   input  logic [W-1:0]     bits,
   output logic [CNT_W-1:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < W; i++) begin
         count = count + CNT_W'(bits[i]);
      end
   end

endmodule

// File: rtl/hd_leakage_accumulator.sv
// Per-sample Hamming-distance power estimate, accumulated and peak-tracked
// over a fixed-length trace; result handed off on a valid/ready port.
//
// state | meaning
// IDLE  | waiting for start; no samples accepted
// ACCUM | accepting samples, accumulating distance and peak
// DONE  | result presented on out_*, waiting for out_ready
module hd_leakage_accumulator
   import hd_leakage_accumulator_pkg::*;
#(
   parameter int TRACE_LEN = 16,
   parameter int ACC_W     = ACC_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] enca,
   input  logic [SUM_W-1:0]  sum,
   output logic              sample_valid,
   output logic [HD_W-1:0]   sample_hd,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_total,
   output logic [HD_W-1:0]   out_peak
);

   localparam int CNT_W  = (TRACE_LEN > 1) ? $clog2(TRACE_LEN) : 1;
   localparam int PCA_W  = $clog2(DATA_W + 1);
   localparam int PCS_W  = $clog2(SUM_W + 1);
   localparam int ACC_W1 = ACC_W + 1;
   localparam logic [ACC_W-1:0] ACC_SAT = {ACC_W{1'b1}};

   state_t             state, state_nxt;
   logic [DATA_W-1:0]  prev_enca;
   logic [SUM_W-1:0]   prev_sum;
   logic [ACC_W-1:0]   acc, acc_nxt;
   logic [ACC_W1-1:0]  acc_wide;
   logic [HD_W-1:0]    peak, peak_nxt, hd;
   logic [CNT_W-1:0]   count;
   logic [PCA_W-1:0]   pc_a;
   logic [PCS_W-1:0]   pc_s;
   logic               accept, last;

   hd_popcount #(.W(DATA_W)) u_pc_enca (
      .bits  (enca ^ prev_enca),
      .count (pc_a)
   );

   hd_popcount #(.W(SUM_W)) u_pc_sum (
      .bits  (sum ^ prev_sum),
      .count (pc_s)
   );

   assign hd       = HD_W'(pc_a) + HD_W'(pc_s);
   assign acc_wide = {1'b0, acc} + ACC_W1'(hd);
   assign acc_nxt  = acc_wide[ACC_W] ? ACC_SAT : acc_wide[ACC_W-1:0];
   assign peak_nxt = (hd > peak) ? hd : peak;
   assign last     = (count == CNT_W'(TRACE_LEN - 1));
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = ACCUM;
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_enca    <= '0;
         prev_sum     <= '0;
         acc          <= '0;
         peak         <= '0;
         count        <= '0;
         sample_valid <= 1'b0;
         sample_hd    <= '0;
         out_total    <= '0;
         out_peak     <= '0;
      end else begin
         sample_valid <= accept;
         if (state == IDLE && start) begin
            prev_enca <= '0;
            prev_sum  <= '0;
            acc       <= '0;
            peak      <= '0;
            count     <= '0;
         end
         if (accept) begin
            sample_hd <= hd;
            prev_enca <= enca;
            prev_sum  <= sum;
            acc       <= acc_nxt;
            peak      <= peak_nxt;
            count     <= last ? '0 : count + CNT_W'(1);
            // final sample is folded into the reported result on the same edge
            if (last) begin
               out_total <= acc_nxt;
               out_peak  <= peak_nxt;
            end
         end
      end
   end

endmodule

// File: doc/hd_leakage_accumulator.md
Name: hd_leakage_accumulator

Overview:
- Downstream stage of the keyed adder datapath (key-XOR oracle followed by 4-bit ripple-carry adder).
- Consumes each encrypted operand (enca) and adder result (sum incl. carry-out), one sample per handshake.
- Computes a Hamming-distance power estimate per sample and accumulates it over a fixed-length trace.
- Reports the trace total and peak to the analysis side through a valid/ready result port.

Parameters:
- DATA_W, 4, width of enca.
- SUM_W, 5, width of sum (DATA_W+1, carry-out is the MSB).
- TRACE_LEN, 16, samples per trace; legal range 1..4096.
- ACC_W, 16, accumulator/total width.
- HD_W, 4, per-sample distance width; must hold DATA_W+SUM_W.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a trace.
- in_valid  in  1  sample present.
- in_ready  out  1  block accepts a sample.
- enca  in  DATA_W  oracle output (operand a XOR key).
- sum  in  SUM_W  adder sum, carry-out in the MSB.
- sample_valid  out  1  per-sample strobe.
- sample_hd  out  HD_W  per-sample Hamming distance.
- busy  out  1  high in ACCUM and DONE.
- out_valid  out  1  trace result available.
- out_ready  in  1  consumer takes the result.
- out_total  out  ACC_W  accumulated distance for the trace.
- out_peak  out  HD_W  largest sample_hd in the trace.

Behaviour:
- Reset is asynchronous and active-low; one clock, clk.
- Reset values: state IDLE; all outputs 0; internal prev_enca, prev_sum, acc, count and peak all 0.
- State IDLE:
  - in_ready=0.
  - start=1 moves to ACCUM next cycle.
  - On that edge: acc=0, peak=0, count=0, prev_enca=0, prev_sum=0.
  - The first sample's distance is therefore its Hamming weight.
- State ACCUM:
  - in_ready=1.
  - Accept occurs when in_valid & in_ready.
  - On accept: hd = popcount(enca ^ prev_enca) + popcount(sum ^ prev_sum).
  - prev_enca and prev_sum are updated to the current inputs.
  - acc = acc + hd, saturating at 2^ACC_W-1.
  - peak = max(peak, hd).
  - count increments.
  - start is ignored in this state.
- sample_valid / sample_hd:
  - Registered; sample_valid is high for exactly the cycle after each accept.
  - sample_hd is held at its last value otherwise.
  - Latency from accept to sample_valid is 1 cycle.
- ACCUM to DONE:
  - The accept with count == TRACE_LEN-1 moves the block to DONE on the same edge.
  - On that edge, out_total and out_peak are loaded with the final acc and peak, including that sample.
  - out_valid=1 from the next cycle.
- State DONE:
  - in_ready=0; out_total and out_peak are held stable; start is ignored.
  - out_valid & out_ready moves to IDLE next cycle, with out_valid=0.
  - out_total and out_peak keep their values until the next trace completes.
- Back-to-back traces:
  - start arriving in the same cycle as the out_valid & out_ready handshake is ignored.
  - start is honoured only in IDLE, so the minimum gap between traces is one IDLE cycle.
- busy = (state != IDLE).
- Gaps with in_valid=0 in ACCUM do not change any state.
- TRACE_LEN=1: the first accept goes directly to DONE.
- Reset mid-trace: all state returns to reset values immediately. There is no partial result and out_valid stays 0.
- Inputs are sampled only on accept; enca and sum need not be stable otherwise.

Decomposition:
- Shared package: state enum (IDLE, ACCUM, DONE), the default widths DATA_W/SUM_W/HD_W, and the saturation constant ACC_MAX.
- One sub-module, hd_popcount:
  - Parameterised width, purely combinational.
  - Instantiated twice, once for enca and once for sum.
- FSM, accumulator and registers stay in the top module.

Test Plan:
- Single-sample hamming weight:
  - Stimulus: TRACE_LEN=1, start, then sample enca=4'b0011, sum=5'b00101 (a=9, k=1010, b=1, c=1).
  - Required response: sample_hd=4; out_total=4, out_peak=4; out_valid held until out_ready.
- Four-sample trace:
  - Stimulus: TRACE_LEN=4, samples (enca,sum) = (3,5), (3,5), (15,16), (0,0).
  - Required response: sample_hd = 4, 0, 5, 5; out_total=14, out_peak=5.
- Backpressure and gaps:
  - Stimulus: the same four samples with in_valid idle cycles between them, and out_ready low for 5 cycles after DONE.
  - Required response: identical results; out_valid and out_total stay stable throughout the stall; start pulsed during the stall is ignored.
- Saturation:
  - Stimulus: ACC_W=4, TRACE_LEN=4, samples alternating (0,0) and (15,31) starting with (15,31).
  - Required response: each hd=9; out_total=15 (saturated); out_peak=9.
- Reset mid-trace:
  - Stimulus: rst_n low after 2 of 4 samples.
  - Required response: busy=0 and in_ready=0 immediately; sample_valid=0. After release, a new trace of (3,5) x4 gives out_total=4 (counting restarts from zero).
